instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch
//   Single-outstanding instruction fetch unit. Issues one memory read per
//   instruction, latches the returned word into IR and presents it, decoded
//   into fixed bit fields, until the downstream stage consumes it.
//   Redirects override any in-flight fetch. An unacknowledged request that
//   waits ACK_TIMEOUT cycles parks the unit in a sticky fault state that only
//   rst can leave.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   imem_req / imem_addr  read request and address (address is always the PC)
//   imem_ack / imem_rdata read completion and returned instruction word
//   stall                 downstream hold of the presented instruction
//   branch_en / target    one-cycle redirect; target is forced word-aligned
//   valid, pc_out         presented instruction is live / its address
//   OP RS RT RD FUNCT IMM JADDR   combinational slices of IR
//   fault                 sticky memory-timeout flag
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        valid,
  output logic [4:0]  OP,
  output logic [4:0]  RS,
  output logic [4:0]  RT,
  output logic [4:0]  RD,
  output logic [5:0]  FUNCT,
  output logic [15:0] IMM,
  output logic [26:0] JADDR,
  output logic [31:0] pc_out,
  output logic        fault
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  // Value of the wait counter during the last cycle a request may go unanswered.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERROR} state_t;

  state_t            state, state_nxt;
  logic [31:0]       pc, pc_nxt;
  logic [31:0]       ir, ir_nxt;
  logic [31:0]       pc_out_nxt;
  logic              valid_nxt;
  logic              fault_nxt;
  logic [CNT_W-1:0]  wcnt, wcnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      ir     <= 32'h0;
      pc_out <= RESET_PC;
      valid  <= 1'b0;
      fault  <= 1'b0;
      wcnt   <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      ir     <= ir_nxt;
      pc_out <= pc_out_nxt;
      valid  <= valid_nxt;
      fault  <= fault_nxt;
      wcnt   <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    pc_out_nxt = pc_out;
    valid_nxt  = valid;
    fault_nxt  = fault;
    wcnt_nxt   = wcnt;

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ack) begin
          ir_nxt     = imem_rdata;
          pc_out_nxt = pc;
          pc_nxt     = pc + 32'd4;   // wraps modulo 2^32 silently
          valid_nxt  = 1'b1;
          wcnt_nxt   = '0;
          state_nxt  = HOLD;
        end else if (wcnt == WAIT_LAST) begin
          state_nxt = ERROR;
          fault_nxt = 1'b1;
          valid_nxt = 1'b0;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end
      end
      default: ;  // ERROR is absorbing until reset
    endcase

    // A redirect overrides both a coincident ack (word dropped, PC not
    // advanced) and a stall; it has no effect once faulted.
    if (branch_en && state != ERROR) begin
      pc_nxt    = {branch_target[31:2], 2'b00};
      ir_nxt    = ir;
      pc_out_nxt = pc_out;
      valid_nxt = 1'b0;
      wcnt_nxt  = '0;
      state_nxt = REQ;
    end
  end

  // Gated by rst so no request escapes while reset is asserted, even in the
  // cycle before the first reset edge lands.
  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = pc;

  assign OP    = ir[31:27];
  assign RS    = ir[26:22];
  assign RT    = ir[21:17];
  assign RD    = ir[16:12];
  assign FUNCT = ir[5:0];
  assign IMM   = ir[15:0];
  assign JADDR = ir[26:0];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack;
  logic [31:0] rdata;
  logic        stall;
  logic        br;
  logic [31:0] tgt;

  logic        d0_req, d0_valid, d0_fault;
  logic [31:0] d0_addr, d0_pcout;
  logic [4:0]  d0_op, d0_rs, d0_rt, d0_rd;
  logic [5:0]  d0_funct;
  logic [15:0] d0_imm;
  logic [26:0] d0_jaddr;

  logic        d1_req, d1_valid, d1_fault;
  logic [31:0] d1_addr, d1_pcout;
  logic [4:0]  d1_op, d1_rs, d1_rt, d1_rd;
  logic [5:0]  d1_funct;
  logic [15:0] d1_imm;
  logic [26:0] d1_jaddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(15)) dut0 (
    .clk(clk), .rst(rst),
    .imem_req(d0_req), .imem_addr(d0_addr),
    .imem_ack(ack), .imem_rdata(rdata),
    .stall(stall), .branch_en(br), .branch_target(tgt),
    .valid(d0_valid), .OP(d0_op), .RS(d0_rs), .RT(d0_rt), .RD(d0_rd),
    .FUNCT(d0_funct), .IMM(d0_imm), .JADDR(d0_jaddr),
    .pc_out(d0_pcout), .fault(d0_fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .ACK_TIMEOUT(15)) dut1 (
    .clk(clk), .rst(rst),
    .imem_req(d1_req), .imem_addr(d1_addr),
    .imem_ack(ack), .imem_rdata(rdata),
    .stall(stall), .branch_en(br), .branch_target(tgt),
    .valid(d1_valid), .OP(d1_op), .RS(d1_rs), .RT(d1_rt), .RD(d1_rd),
    .FUNCT(d1_funct), .IMM(d1_imm), .JADDR(d1_jaddr),
    .pc_out(d1_pcout), .fault(d1_fault)
  );

  typedef struct {
    logic        rst, ack, stall, br;
    logic [31:0] rdata, tgt;
    logic        chk;
    logic        e_req, e_valid, e_fault;
    logic [31:0] e_addr, e_pcout;
    logic [4:0]  e_op;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(logic r, logic a, logic s, logic b, logic [31:0] d,
                              logic [31:0] t, logic c, logic eq, logic [31:0] ea,
                              logic ev, logic [4:0] eo, logic [31:0] ep, logic ef);
    vec_t v;
    v.rst = r; v.ack = a; v.stall = s; v.br = b; v.rdata = d; v.tgt = t;
    v.chk = c; v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_op = eo;
    v.e_pcout = ep; v.e_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic s, input logic b,
                       input logic [31:0] d, input logic [31:0] t);
    @(negedge clk);
    rst = r; ack = a; stall = s; br = b; rdata = d; tgt = t;
    #1;
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; stall = 1'b0; br = 1'b0; rdata = '0; tgt = '0;

    //              rst ack stl br  rdata          tgt           chk req addr          vld op  pc_out        fault
    vecs[0]  = mk(1, 1, 0, 0, 32'h0800_0000, 32'h0,        0, 0, 32'h0,         0, 0, 32'h0,         0);
    vecs[1]  = mk(1, 1, 0, 0, 32'h0800_0000, 32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         0);
    vecs[2]  = mk(0, 1, 0, 0, 32'h0800_0000, 32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         0);
    vecs[3]  = mk(0, 1, 0, 0, 32'h0800_0000, 32'h0,        1, 1, 32'h0,         0, 0, 32'h0,         0);
    vecs[4]  = mk(0, 1, 0, 0, 32'h1000_0000, 32'h0,        1, 0, 32'h4,         1, 1, 32'h0,         0);
    vecs[5]  = mk(0, 1, 0, 0, 32'h1000_0000, 32'h0,        1, 1, 32'h4,         0, 1, 32'h0,         0);
    vecs[6]  = mk(0, 1, 1, 0, 32'h1800_0000, 32'h0,        1, 0, 32'h8,         1, 2, 32'h4,         0);
    vecs[7]  = mk(0, 1, 1, 0, 32'h1800_0000, 32'h0,        1, 0, 32'h8,         1, 2, 32'h4,         0);
    vecs[8]  = mk(0, 1, 1, 0, 32'h1800_0000, 32'h0,        1, 0, 32'h8,         1, 2, 32'h4,         0);
    vecs[9]  = mk(0, 1, 0, 0, 32'h1800_0000, 32'h0,        1, 0, 32'h8,         1, 2, 32'h4,         0);
    vecs[10] = mk(0, 1, 0, 1, 32'h1800_0000, 32'h103,      1, 1, 32'h8,         0, 2, 32'h4,         0);
    for (int i = 11; i <= 25; i++)
      vecs[i] = mk(0, 0, 0, 0, 32'h1800_0000, 32'h0,      1, 1, 32'h100,       0, 2, 32'h4,         0);
    vecs[26] = mk(0, 1, 0, 1, 32'h1800_0000, 32'h200,      1, 0, 32'h100,       0, 2, 32'h4,         1);
    vecs[27] = mk(0, 0, 0, 0, 32'h1800_0000, 32'h0,        1, 0, 32'h100,       0, 2, 32'h4,         1);
    vecs[28] = mk(1, 0, 0, 0, 32'h0800_0000, 32'h0,        1, 0, 32'h100,       0, 2, 32'h4,         1);
    vecs[29] = mk(0, 1, 0, 0, 32'h0800_0000, 32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         0);
    vecs[30] = mk(0, 1, 0, 0, 32'h0800_0000, 32'h0,        1, 1, 32'h0,         0, 0, 32'h0,         0);
    vecs[31] = mk(0, 1, 0, 0, 32'hF800_0000, 32'h0,        1, 0, 32'h4,         1, 1, 32'h0,         0);
    vecs[32] = mk(1, 1, 0, 0, 32'hF800_0000, 32'h0,        1, 0, 32'h4,         0, 1, 32'h0,         0);
    vecs[33] = mk(0, 0, 0, 0, 32'h0,         32'h0,        1, 0, 32'h0,         0, 0, 32'h0,         0);

    for (int i = 0; i < 34; i++) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].stall, vecs[i].br, vecs[i].rdata, vecs[i].tgt);
      if (vecs[i].chk) begin
        check($sformatf("v%0d req", i),    {31'b0, d0_req},   {31'b0, vecs[i].e_req});
        check($sformatf("v%0d addr", i),   d0_addr,           vecs[i].e_addr);
        check($sformatf("v%0d valid", i),  {31'b0, d0_valid}, {31'b0, vecs[i].e_valid});
        check($sformatf("v%0d op", i),     {27'b0, d0_op},    {27'b0, vecs[i].e_op});
        check($sformatf("v%0d pc_out", i), d0_pcout,          vecs[i].e_pcout);
        check($sformatf("v%0d fault", i),  {31'b0, d0_fault}, {31'b0, vecs[i].e_fault});
      end
    end

    // PC wrap on dut1, field slicing, and branch overriding stall on dut0.
    drive(1, 1, 0, 0, 32'h2A5A_C3F5, 32'h0);
    drive(1, 1, 0, 0, 32'h2A5A_C3F5, 32'h0);
    drive(0, 1, 0, 0, 32'h2A5A_C3F5, 32'h0);
    check("wrap idle req",   {31'b0, d1_req}, 32'h0);
    check("wrap idle addr",  d1_addr,  32'hFFFF_FFFC);
    check("wrap reset pc_out", d1_pcout, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 32'h2A5A_C3F5, 32'h0);
    check("wrap req",        {31'b0, d1_req}, 32'h1);
    check("wrap req addr",   d1_addr,  32'hFFFF_FFFC);
    drive(0, 1, 1, 0, 32'h2A5A_C3F5, 32'h0);
    check("wrap valid",      {31'b0, d1_valid}, 32'h1);
    check("wrap pc_out",     d1_pcout, 32'hFFFF_FFFC);
    check("wrap next addr",  d1_addr,  32'h0);
    check("field OP",    {27'b0, d1_op},    32'h5);
    check("field RS",    {27'b0, d1_rs},    32'h9);
    check("field RT",    {27'b0, d1_rt},    32'hD);
    check("field RD",    {27'b0, d1_rd},    32'hC);
    check("field FUNCT", {26'b0, d1_funct}, 32'h35);
    check("field IMM",   {16'b0, d1_imm},   32'hC3F5);
    check("field JADDR", {5'b0, d1_jaddr},  32'h025A_C3F5);
    drive(0, 1, 1, 1, 32'h2A5A_C3F5, 32'h0000_0041);
    check("stall hold valid", {31'b0, d0_valid}, 32'h1);
    check("stall no req",     {31'b0, d0_req},   32'h0);
    drive(0, 1, 0, 0, 32'h2A5A_C3F5, 32'h0);
    check("br>stall req",   {31'b0, d0_req},   32'h1);
    check("br>stall addr",  d0_addr,           32'h40);
    check("br>stall valid", {31'b0, d0_valid}, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    check("after br valid",  {31'b0, d0_valid}, 32'h1);
    check("after br pc_out", d0_pcout,          32'h40);
    check("after br addr",   d0_addr,           32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
